// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard frame receiver and scan-code assembler.
// Ports: clk (system clock), resetn (sync active-low reset),
//        ps2_clk / ps2_data (async PS/2 lines),
//        scancode[15:0] ({E0,byte} or {00,byte}), brk (release flag),
//        code_valid (1-cycle pulse on new code), frame_err (1-cycle pulse on dropped frame).
// Parameter TIMEOUT_CYCLES: idle clk cycles before a partial frame is aborted.
// Macro PS2_PARITY_CHECK_EN: when defined, odd parity is enforced.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] scancode,
    output logic        brk,
    output logic        code_valid,
    output logic        frame_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]  clk_sync, data_sync;
    logic        clk_prev;
    logic [1:0]  state;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic [15:0] idle_cnt;
    logic        byte_ok, ext, brk_pend;
    logic        fall, bit_in, par_ok, stop_err, timeout;
`ifdef PS2_PARITY_CHECK_EN
    logic        par;
`endif

    always_comb begin
        fall     = clk_prev & ~clk_sync[1];
        bit_in   = data_sync[1];
`ifdef PS2_PARITY_CHECK_EN
        par_ok   = ^{shreg, par};
`else
        par_ok   = 1'b1;
`endif
        stop_err = fall && state == STOP && !(bit_in && par_ok);
        // a sample event arriving on the deadline cycle wins over the timeout
        timeout  = !fall && state != IDLE && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            par        <= 1'b0;
`endif
            idle_cnt   <= 16'd0;
            byte_ok    <= 1'b0;
            ext        <= 1'b0;
            brk_pend   <= 1'b0;
            scancode   <= 16'h0000;
            brk        <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            byte_ok    <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= stop_err | timeout;
            idle_cnt   <= (fall || timeout || state == IDLE) ? 16'd0 : idle_cnt + 16'd1;
            if (fall) begin
                case (state)
                    IDLE: if (!bit_in) begin
                        state  <= DATA;
                        bitcnt <= 3'd0;
                    end
                    DATA: begin
                        shreg  <= {bit_in, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par   <= bit_in;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        byte_ok <= bit_in && par_ok;
                        state   <= IDLE;
                    end
                endcase
            end else if (timeout) begin
                state <= IDLE;
            end
            // shreg stays put while IDLE, so it still holds the accepted byte here
            if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    scancode   <= {ext ? 8'hE0 : 8'h00, shreg};
                    brk        <= brk_pend;
                    code_valid <= 1'b1;
                    ext        <= 1'b0;
                    brk_pend   <= 1'b0;
                end
            end
            if (stop_err || timeout) begin
                ext      <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed self-checking bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;
    localparam int TMO = 300;
    localparam int H   = 10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] scancode;
    logic        brk, code_valid, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cv0, fe0;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .brk(brk), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (code_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one PS/2 bit: data set up, clock falls, clock rises
    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        idle(H);
        ps2_clk = 1'b0;
        idle(H);
        ps2_clk = 1'b1;
    endtask

    // full frame; checks frame_err at T+1 and code_valid at T+2 of the stop sample
    task automatic send(input string tag, input logic [7:0] b, input logic flip, input logic badstop,
                        input logic exp_fe, input logic exp_cv);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        @(negedge clk) ps2_data = ~badstop;
        idle(H);
        ps2_clk = 1'b0;
        idle(2);
        @(negedge clk);
        chk({tag, ".fe"}, {31'd0, frame_err}, {31'd0, exp_fe});
        chk({tag, ".cv_early"}, {31'd0, code_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".cv"}, {31'd0, code_valid}, {31'd0, exp_cv});
        idle(H);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(H);
    endtask

    // start bit plus n data bits, leaving ps2_clk low right after the last fall
    task automatic partial(input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n - 1; i++) ps2_bit(1'b1);
        @(negedge clk) ps2_data = 1'b0;
        idle(H);
        ps2_clk = 1'b0;
    endtask

    initial begin
        idle(5);
        chk("rst.scancode", {16'd0, scancode}, 32'h0);
        chk("rst.brk", {31'd0, brk}, 32'd0);
        chk("rst.cv", {31'd0, code_valid}, 32'd0);
        chk("rst.fe", {31'd0, frame_err}, 32'd0);
        resetn = 1'b1;
        idle(5);

        cv0 = cv_cnt;
        send("e0", 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("6b", 8'h6B, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("e06b.code", {16'd0, scancode}, 32'hE06B);
        chk("e06b.brk", {31'd0, brk}, 32'd0);
        chk("e06b.pulses", cv_cnt - cv0, 32'd1);

        cv0 = cv_cnt;
        send("e0b", 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("f0", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("72", 8'h72, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("e072.code", {16'd0, scancode}, 32'hE072);
        chk("e072.brk", {31'd0, brk}, 32'd1);
        chk("e072.pulses", cv_cnt - cv0, 32'd1);

        send("1c", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("1c.code", {16'd0, scancode}, 32'h001C);
        chk("1c.brk", {31'd0, brk}, 32'd0);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        idle(1000);
        chk("hold.code", {16'd0, scancode}, 32'h001C);
        chk("hold.brk", {31'd0, brk}, 32'd0);
        chk("hold.cv", cv_cnt - cv0, 32'd0);
        chk("hold.fe", fe_cnt - fe0, 32'd0);

`ifdef PS2_PARITY_CHECK_EN
        send("75bad", 8'h75, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("75bad.code", {16'd0, scancode}, 32'h001C);
`else
        send("75bad", 8'h75, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("75bad.code", {16'd0, scancode}, 32'h0075);
`endif

        send("e1", 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("e1.code", {16'd0, scancode}, 32'h00E1);

        send("f0a", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("f0b", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("f0f05a.code", {16'd0, scancode}, 32'h005A);
        chk("f0f05a.brk", {31'd0, brk}, 32'd1);

        send("e0c", 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("badstop", 8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
        send("after_stop", 8'h29, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_stop.code", {16'd0, scancode}, 32'h0029);

        send("e0d", 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        cv0 = cv_cnt;
        partial(5);
        idle(TMO + 2);
        chk("tmo.early", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        chk("tmo.fe", {31'd0, frame_err}, 32'd1);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(H);
        chk("tmo.cv", cv_cnt - cv0, 32'd0);
        send("74", 8'h74, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("74.code", {16'd0, scancode}, 32'h0074);
        chk("74.brk", {31'd0, brk}, 32'd0);

        fe0 = fe_cnt;
        partial(4);
        idle(H);
        ps2_clk = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst.code", {16'd0, scancode}, 32'h0);
        chk("mrst.brk", {31'd0, brk}, 32'd0);
        chk("mrst.cv", {31'd0, code_valid}, 32'd0);
        resetn = 1'b1;
        ps2_data = 1'b1;
        idle(TMO + 50);
        chk("mrst.nofe", fe_cnt - fe0, 32'd0);
        send("6b_after", 8'h6B, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("6b_after.code", {16'd0, scancode}, 32'h006B);
        chk("excl", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
